// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch front end.
// Issues req/gnt/rvalid fetches, holds one instruction for decode and applies execute redirects.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [1:0]  next_pc_sel,
   input  logic [31:0] branch_target,
   input  logic [31:0] jalr_target,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        misalign_trap,
   output logic [31:0] trap_addr
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state_r, state_nxt_s;
   logic [31:0] pc_r, pc_nxt_s;
   logic        drop_r, drop_nxt_s;
   logic        halt_r, halt_nxt_s;
   logic        req_r;
   logic        valid_r, valid_nxt_s;
   logic [31:0] instr_r, instr_nxt_s;
   logic [31:0] ipc_r, ipc_nxt_s;
   logic        trap_r, trap_nxt_s;
   logic [31:0] taddr_r, taddr_nxt_s;

   logic        redir_s;
   logic        misalign_s;
   logic        redir_ok_s;
   logic        accept_s;
   logic        inflight_s;
   logic [31:0] target_s;
   logic [31:0] pc_inc_s;

   function automatic logic [31:0] sel_target(input logic [1:0]  sel,
                                              input logic [31:0] br,
                                              input logic [31:0] jr);
      logic [31:0] t;
      case (sel)
         2'b11:        t = jr & 32'hFFFF_FFFE;
         2'b01, 2'b10: t = br;
         default:      t = br;
      endcase
      return t;
   endfunction

   assign target_s   = sel_target(next_pc_sel, branch_target, jalr_target);
   assign redir_s    = redirect_valid & (next_pc_sel != 2'b00);
   assign misalign_s = redir_s & (target_s[1:0] != 2'b00);
   assign redir_ok_s = redir_s & ~misalign_s;
   assign accept_s   = (state_r == S_HOLD) & instr_ready & ~stall;
   assign pc_inc_s   = pc_r + 32'd4;

   // A response is still owed by memory after this edge and must be swallowed
   assign inflight_s = ((state_r == S_REQ) & imem_gnt)
                     | ((state_r == S_WAIT) & ~imem_rvalid)
                     | (drop_r & ~imem_rvalid);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and datapath update selection
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      drop_nxt_s  = drop_r;
      halt_nxt_s  = halt_r;
      valid_nxt_s = valid_r;
      instr_nxt_s = instr_r;
      ipc_nxt_s   = ipc_r;
      trap_nxt_s  = 1'b0;
      taddr_nxt_s = taddr_r;
      if (misalign_s) begin
         trap_nxt_s  = 1'b1;
         taddr_nxt_s = target_s;
         halt_nxt_s  = 1'b1;
         valid_nxt_s = 1'b0;
         instr_nxt_s = NOP_INSTR;
         drop_nxt_s  = inflight_s;
         state_nxt_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               drop_nxt_s = drop_r & ~imem_rvalid;
               if (redir_ok_s) begin
                  pc_nxt_s    = target_s;
                  halt_nxt_s  = 1'b0;
                  // a stale response from before the trap must drain before a new request
                  state_nxt_s = (drop_r & ~imem_rvalid) ? S_WAIT : S_REQ;
               end else if (!halt_r) begin
                  state_nxt_s = S_REQ;
               end else begin
                  state_nxt_s = S_IDLE;
               end
            end
            S_REQ: begin
               if (redir_ok_s) begin
                  pc_nxt_s = target_s;
               end else begin
                  pc_nxt_s = pc_r;
               end
               if (imem_gnt) begin
                  state_nxt_s = S_WAIT;
                  drop_nxt_s  = redir_ok_s;
               end else begin
                  state_nxt_s = S_REQ;
               end
            end
            S_WAIT: begin
               if (redir_ok_s) begin
                  pc_nxt_s = target_s;
               end else begin
                  pc_nxt_s = pc_r;
               end
               if (imem_rvalid) begin
                  drop_nxt_s = 1'b0;
                  if (drop_r | redir_ok_s) begin
                     state_nxt_s = S_REQ;
                  end else begin
                     state_nxt_s = S_HOLD;
                     valid_nxt_s = 1'b1;
                     instr_nxt_s = imem_rdata;
                     ipc_nxt_s   = pc_r;
                  end
               end else begin
                  drop_nxt_s  = drop_r | redir_ok_s;
                  state_nxt_s = S_WAIT;
               end
            end
            S_HOLD: begin
               if (redir_ok_s) begin
                  pc_nxt_s    = target_s;
                  valid_nxt_s = 1'b0;
                  instr_nxt_s = NOP_INSTR;
                  state_nxt_s = S_REQ;
               end else if (accept_s) begin
                  pc_nxt_s    = pc_inc_s;
                  valid_nxt_s = 1'b0;
                  instr_nxt_s = NOP_INSTR;
                  state_nxt_s = S_REQ;
               end else begin
                  state_nxt_s = S_HOLD;
               end
            end
            default: begin
               drop_nxt_s  = 1'b0;
               state_nxt_s = S_IDLE;
            end
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r    <= RESET_PC;
         drop_r  <= 1'b0;
         halt_r  <= 1'b0;
         req_r   <= 1'b0;
         valid_r <= 1'b0;
         instr_r <= NOP_INSTR;
         ipc_r   <= RESET_PC;
         trap_r  <= 1'b0;
         taddr_r <= 32'h0000_0000;
      end else begin
         pc_r    <= pc_nxt_s;
         drop_r  <= drop_nxt_s;
         halt_r  <= halt_nxt_s;
         req_r   <= (state_nxt_s == S_REQ);
         valid_r <= valid_nxt_s;
         instr_r <= instr_nxt_s;
         ipc_r   <= ipc_nxt_s;
         trap_r  <= trap_nxt_s;
         taddr_r <= taddr_nxt_s;
      end
   end

   assign imem_req      = req_r;
   assign imem_addr     = pc_r;
   assign pc            = pc_r;
   assign pc_plus4      = pc_inc_s;
   assign instr_valid   = valid_r;
   assign instr         = instr_r;
   assign instr_pc      = ipc_r;
   assign misalign_trap = trap_r;
   assign trap_addr     = taddr_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized phase,
// checked against an architectural PC model and an address-keyed instruction memory.
module tb_pc_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [1:0]  next_pc_sel;
   logic [31:0] branch_target;
   logic [31:0] jalr_target;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misalign_trap;
   logic [31:0] trap_addr;

   int n_tests = 0;
   int n_fail  = 0;

   // architectural model
   logic [31:0] exp_pc, exp_taddr, held_instr;
   logic        exp_trap, halted, hold_exp;

   // memory responder
   logic        mem_pend;
   int          mem_cnt;
   logic [31:0] mem_addr;
   int          r_min, r_max, gnt_pct;
   logic        granted_last;
   logic [31:0] last_gaddr;
   logic [31:0] gq[$];
   logic [8:0]  mask;

   pc_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .next_pc_sel(next_pc_sel),
      .branch_target(branch_target), .jalr_target(jalr_target), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .pc(pc), .pc_plus4(pc_plus4),
      .misalign_trap(misalign_trap), .trap_addr(trap_addr)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic mem_drive();
      imem_rvalid  = 1'b0;
      imem_rdata   = 32'hDEAD_BEEF;
      imem_gnt     = 1'b0;
      granted_last = 1'b0;
      if (mem_pend) begin
         if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memfn(mem_addr);
            mem_pend    = 1'b0;
         end else begin
            mem_cnt--;
         end
      end
      if (imem_req && !mem_pend && (int'($urandom_range(99, 0)) < gnt_pct)) begin
         imem_gnt     = 1'b1;
         mem_pend     = 1'b1;
         mem_cnt      = int'($urandom_range(r_max, r_min)) - 1;
         mem_addr     = imem_addr;
         granted_last = 1'b1;
         last_gaddr   = imem_addr;
         gq.push_back(imem_addr);
      end
   endtask

   task automatic model_update();
      logic        redir, acc;
      logic [31:0] tgt;
      exp_trap = 1'b0;
      if (!rst_n) begin
         hold_exp = 1'b0;
      end else begin
         redir = redirect_valid && (next_pc_sel != 2'b00);
         tgt   = (next_pc_sel == 2'b11) ? (jalr_target & ~32'd1) : branch_target;
         acc   = instr_valid && instr_ready && !stall;
         if (redir) begin
            if (tgt[1:0] != 2'b00) begin
               exp_trap  = 1'b1;
               exp_taddr = tgt;
               halted    = 1'b1;
            end else begin
               exp_pc = tgt;
               halted = 1'b0;
            end
         end else if (acc) begin
            exp_pc = exp_pc + 32'd4;
         end
         hold_exp   = instr_valid && !acc && !redir;
         held_instr = instr;
      end
   endtask

   task automatic check_all();
      chk32("pc", pc, exp_pc);
      chk32("pc_plus4", pc_plus4, exp_pc + 32'd4);
      chk1("misalign_trap", misalign_trap, exp_trap);
      chk32("trap_addr", trap_addr, exp_taddr);
      if (imem_req) chk32("imem_addr", imem_addr, exp_pc);
      if (halted) chk1("req_while_halted", imem_req, 1'b0);
      if (hold_exp) begin
         chk1("valid_held", instr_valid, 1'b1);
         chk32("instr_held", instr, held_instr);
      end
      if (instr_valid) begin
         chk32("instr_pc", instr_pc, exp_pc);
         chk32("instr_data", instr, memfn(exp_pc));
      end else begin
         chk32("instr_nop", instr, NOP);
      end
   endtask

   task automatic step();
      mem_drive();
      model_update();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (!instr_valid && k < 60) begin
         step();
         k++;
      end
      chk1(tag, instr_valid, 1'b1);
   endtask

   task automatic wait_grant(input string tag, input logic [31:0] exp);
      int k = 0;
      do begin
         step();
         k++;
      end while (!granted_last && k < 60);
      chk1({tag, "_seen"}, granted_last, 1'b1);
      chk32(tag, last_gaddr, exp);
   endtask

   initial begin
      rst_n = 1'b0; redirect_valid = 1'b0; next_pc_sel = 2'b00;
      branch_target = 32'd0; jalr_target = 32'd0; stall = 1'b0; instr_ready = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
      exp_pc = RST_PC; exp_taddr = 32'd0; exp_trap = 1'b0; halted = 1'b0;
      hold_exp = 1'b0; held_instr = NOP;
      mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'd0; r_min = 1; r_max = 1; gnt_pct = 100;
      granted_last = 1'b0; last_gaddr = 32'd0; mask = 9'd0;

      @(negedge clk);
      step();
      step();
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_valid", instr_valid, 1'b0);
      chk32("rst_instr", instr, NOP);
      chk32("rst_instr_pc", instr_pc, RST_PC);
      chk32("rst_pc", pc, RST_PC);
      chk1("rst_trap", misalign_trap, 1'b0);
      chk32("rst_trap_addr", trap_addr, 32'd0);

      // sequential fetch with a 1-cycle grant / 1-cycle response memory
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         if (i == 0) chk1("first_req", imem_req, 1'b1);
         mask[i] = instr_valid;
      end
      chk32("valid_cadence", {23'd0, mask}, 32'h0000_0124);
      chk32("grant_count", 32'(gq.size()), 32'd3);
      chk32("grant0", gq[0], 32'h0000_0100);
      chk32("grant1", gq[1], 32'h0000_0104);
      chk32("grant2", gq[2], 32'h0000_0108);

      // back-pressure then stall: everything frozen, sel=00 redirect ignored
      wait_valid("p2_valid");
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         redirect_valid = 1'b1; next_pc_sel = 2'b00; branch_target = 32'h0000_0800;
         step();
         chk32("freeze_instr", instr, memfn(32'h0000_0108));
         chk32("freeze_ipc", instr_pc, 32'h0000_0108);
         chk32("freeze_pc", pc, 32'h0000_0108);
      end
      redirect_valid = 1'b0;
      instr_ready = 1'b1;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk32("stall_instr", instr, memfn(32'h0000_0108));
         chk32("stall_ipc", instr_pc, 32'h0000_0108);
         chk32("stall_pc", pc, 32'h0000_0108);
      end
      stall = 1'b0;
      step();
      chk32("advance_pc", pc, 32'h0000_010C);
      chk1("advance_valid", instr_valid, 1'b0);

      // branch redirect while a response is in flight
      r_min = 3; r_max = 3;
      wait_grant("p3_grant", 32'h0000_010C);
      redirect_valid = 1'b1; next_pc_sel = 2'b01; branch_target = 32'h0000_0200;
      step();
      redirect_valid = 1'b0;
      r_min = 1; r_max = 1;
      wait_grant("p3_redirect_fetch", 32'h0000_0200);

      // jalr clears bit 0 and is not a trap
      wait_valid("p4_valid");
      instr_ready = 1'b0;
      redirect_valid = 1'b1; next_pc_sel = 2'b11;
      jalr_target = 32'h0000_0301; branch_target = 32'h0000_0777;
      step();
      redirect_valid = 1'b0;
      chk32("p4_pc", pc, 32'h0000_0300);
      chk1("p4_no_trap", misalign_trap, 1'b0);
      instr_ready = 1'b1;
      wait_grant("p4_fetch", 32'h0000_0300);

      // misaligned jal target traps and halts fetch until an aligned redirect
      wait_valid("p5_valid");
      instr_ready = 1'b0;
      redirect_valid = 1'b1; next_pc_sel = 2'b10;
      branch_target = 32'h0000_0402; jalr_target = 32'h0000_0500;
      step();
      redirect_valid = 1'b0;
      chk1("p5_trap", misalign_trap, 1'b1);
      chk32("p5_taddr", trap_addr, 32'h0000_0402);
      chk32("p5_pc", pc, 32'h0000_0300);
      chk1("p5_dropped", instr_valid, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk1("p5_req_idle", imem_req, 1'b0);
         chk1("p5_trap_pulse", misalign_trap, 1'b0);
         chk32("p5_taddr_hold", trap_addr, 32'h0000_0402);
      end
      redirect_valid = 1'b1; next_pc_sel = 2'b01; branch_target = 32'h0000_0500;
      step();
      redirect_valid = 1'b0;
      instr_ready = 1'b1;
      chk32("p5_pc_redirect", pc, 32'h0000_0500);
      wait_grant("p5_fetch", 32'h0000_0500);

      // randomized traffic
      r_min = 1; r_max = 3; gnt_pct = 60;
      for (int i = 0; i < 400; i++) begin
         logic [31:0] base;
         logic        mis;
         instr_ready = ($urandom_range(9, 0) < 7);
         stall       = ($urandom_range(9, 0) < 2);
         base        = 32'h0000_1000 + ($urandom_range(255, 0) << 2);
         mis         = ($urandom_range(4, 0) == 0);
         redirect_valid = ($urandom_range(11, 0) == 0);
         next_pc_sel    = 2'($urandom_range(3, 0));
         branch_target  = mis ? (base | 32'($urandom_range(3, 1))) : base;
         jalr_target    = base | 32'($urandom_range(1, 0)) | (mis ? 32'd2 : 32'd0);
         step();
      end
      redirect_valid = 1'b0; stall = 1'b0; gnt_pct = 100; r_min = 1; r_max = 1;

      // PC wrap, then asynchronous reset while a response is outstanding
      instr_ready = 1'b0;
      redirect_valid = 1'b1; next_pc_sel = 2'b01; branch_target = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      wait_valid("p7_valid");
      chk32("p7_pc_plus4", pc_plus4, 32'h0000_0000);
      instr_ready = 1'b1;
      r_min = 4; r_max = 4;
      wait_grant("p7_wrap_fetch", 32'h0000_0000);
      #2;
      rst_n = 1'b0;
      #1;
      chk1("arst_req", imem_req, 1'b0);
      chk1("arst_valid", instr_valid, 1'b0);
      chk32("arst_instr", instr, NOP);
      chk32("arst_instr_pc", instr_pc, RST_PC);
      chk32("arst_pc", pc, RST_PC);
      chk1("arst_trap", misalign_trap, 1'b0);
      chk32("arst_trap_addr", trap_addr, 32'd0);
      exp_pc = RST_PC; exp_taddr = 32'd0; exp_trap = 1'b0; halted = 1'b0; hold_exp = 1'b0;
      r_min = 1; r_max = 1;
      @(negedge clk);
      step();
      rst_n = 1'b1;
      wait_grant("p7_post_reset_fetch", RST_PC);
      wait_valid("p7_post_reset_valid");
      chk32("p7_post_reset_instr", instr, memfn(RST_PC));
      chk32("p7_post_reset_ipc", instr_pc, RST_PC);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch front end of the RISC-V core. Holds the architectural PC, fetches from instruction memory over a request/grant/response handshake, and presents one instruction at a time to decode. Produces `pc` and `pc_plus4` for the 32-bit ripple adder. Consumes the branch and jump targets that adder computes, and redirects the fetch stream when the execute stage requests it.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: value driven on `instr` when no instruction is valid.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  execute requests a PC change this cycle.
- `next_pc_sel`  in  2  redirect kind, sampled with `redirect_valid`: 01 branch taken, 10 jal, 11 jalr; 00 ignored.
- `branch_target`  in  32  pc+imm from the adder; used for 01 and 10.
- `jalr_target`  in  32  rs1+imm from the adder; used for 11 with bit 0 cleared.
- `stall`  in  1  hazard stall; blocks instruction acceptance.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals `pc` while `imem_req` is high.
- `imem_gnt`  in  1  memory accepted the request.
- `imem_rvalid`  in  1  response data valid, 1 or more cycles after the grant.
- `imem_rdata`  in  32  fetched word.
- `instr_valid`  out  1  `instr` and `instr_pc` are valid.
- `instr`  out  32  fetched instruction.
- `instr_pc`  out  32  address of `instr`.
- `instr_ready`  in  1  decode accepts the instruction.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc`+4 modulo 2^32; combinational.
- `misalign_trap`  out  1  one-cycle pulse on a misaligned redirect target.
- `trap_addr`  out  32  offending target; held until the next trap.

## Operation
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE: no request outstanding.
  - REQ: `imem_req`=1 until `imem_gnt`.
  - WAIT: granted; waiting for `imem_rvalid`.
  - HOLD: `instr_valid`=1 until accepted.
- Transitions:
  - IDLE -> REQ unconditionally, except after a trap (see below).
  - REQ -> WAIT on `imem_gnt`.
  - WAIT -> HOLD on `imem_rvalid`. `instr` and `instr_pc` are captured at that edge.
  - HOLD -> REQ when accepted, i.e. `instr_valid & instr_ready & ~stall`. `pc` advances to `pc_plus4`.
- Redirect target selection: 01 or 10 take `branch_target`; 11 takes `{jalr_target[31:1],1'b0}`.
- A redirect has priority over stall and over sequential advance.
- If `target[1:0]`!=0 on a redirect:
  - `misalign_trap`=1 for one cycle and `trap_addr`=target.
  - `pc` is unchanged and any held instruction is dropped.
  - The FSM goes to IDLE and stays there until the next valid, aligned redirect.
- Redirect with an aligned target, by state:
  - IDLE or HOLD: `pc`<=target, `instr_valid`<=0, go to REQ.
  - REQ before grant: `pc` and `imem_addr` update next cycle; `imem_req` stays high.
  - REQ in the same cycle as `imem_gnt`: treated like WAIT.
  - WAIT: `pc`<=target and a drop flag is set. The next `imem_rvalid` is discarded and clears the flag, then the FSM goes to REQ. Only one response is ever outstanding.
- `next_pc_sel`=00 with `redirect_valid`=1 is a no-op.

## Timing
- Reset values, all asynchronous:
  - `pc`=RESET_PC; state IDLE.
  - `imem_req`=0, `instr_valid`=0, `instr`=NOP_INSTR, `instr_pc`=RESET_PC.
  - `misalign_trap`=0, `trap_addr`=0; drop flag cleared.
- First request: `imem_req` rises one cycle after `rst_n` deasserts.
- Best-case fetch latency: 1 cycle REQ with immediate grant, plus 1 cycle WAIT with next-cycle rvalid. The instruction is valid 2 cycles after the request. Sustained throughput is 1 instruction per 3 cycles.
- `instr` and `instr_pc` are stable while `instr_valid` is high and not accepted.
- Redirect to first request at the target: 1 cycle from IDLE, REQ or HOLD; from WAIT, 1 cycle after the discarded response.
- `pc_plus4` wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- A reset asserted mid-transaction abandons any outstanding response. An `imem_rvalid` arriving after reset while in IDLE or REQ is ignored.

## Test plan
- Reset release with RESET_PC=32'h0000_0100 and memory with 1-cycle grant and 1-cycle rvalid -> `imem_addr` sequence 0x100, 0x104, 0x108. `instr_pc` matches each address. `instr_valid` pulses every 3rd cycle.
- Hold `instr_ready`=0 for 5 cycles, then assert `stall`=1 with `instr_ready`=1 -> `instr`, `instr_pc` and `pc` all frozen. `pc` advances by 4 only after `stall` drops.
- `redirect_valid` with sel=01, `branch_target`=0x200 during WAIT -> the in-flight rdata is never presented. The next `imem_addr` is 0x200.
- sel=11, `jalr_target`=0x301 -> `pc`=0x300 and a fetch at 0x300; `misalign_trap` stays 0.
- sel=10, `branch_target`=0x402 -> `misalign_trap` pulses for 1 cycle with `trap_addr`=0x402. `pc` is unchanged and `imem_req` stays 0 until an aligned redirect to 0x500, which then fetches 0x500.
- `pc`=0xFFFF_FFFC accepted -> `pc_plus4` and the next `imem_addr` are 0x0000_0000. Assert `rst_n` low during WAIT -> all outputs take their reset values immediately, and a late rvalid is ignored.
